// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage load/store controller.
package mem_access_ctrl_pkg;

    localparam int RAM_SPACE_DEFAULT = 4194304;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2
    } err_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } state_t;

    // Size code 3 has no legal access, so it is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response bus of the load/store controller.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// Selects the addressed byte/half from a big-endian RAM word and extends it.
module lsu_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        zero_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select (offset 0 is bits [31:24]) followed by zero/sign extension.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data     = rdata;
        case (offset)
            2'd0: byte_sel = rdata[31:24];
            2'd1: byte_sel = rdata[23:16];
            2'd2: byte_sel = rdata[15:8];
            2'd3: byte_sel = rdata[7:0];
            default: byte_sel = 8'h00;
        endcase
        half_sel = offset[1] ? rdata[15:0] : rdata[31:16];
        case (size)
            SZ_B:    data = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
            SZ_H:    data = {{16{~zero_ext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller in front of a 1-cycle-latency synchronous RAM.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int RAM_SPACE = RAM_SPACE_DEFAULT
) (
    input  logic               clk,
    input  logic               rstn,
    mem_access_ctrl_if.slave   bus,
    output logic               mem_en,
    output logic [3:0]         mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    state_t      state, state_nxt;
    err_t        req_err;
    logic        accept;
    logic        mem_active;
    size_t       cap_size;
    logic [1:0]  cap_offset;
    logic        cap_zero_ext;
    logic [31:0] load_data;
    logic [31:0] resp_rdata_q;
    err_t        resp_err_q;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign accept = (state == IDLE) && bus.req_valid;
    // rstn gates the RAM side so nothing reaches the RAM while reset is held.
    assign mem_active = rstn && accept && (req_err == ERR_OK);

    // Classify the request; misalignment wins over out-of-range.
    always_comb begin
        req_err = ERR_OK;
        if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            req_err = ERR_ALIGN;
        end else if ({2'b00, bus.req_addr[31:2]} >= 32'(RAM_SPACE)) begin
            req_err = ERR_RANGE;
        end
    end

    // RAM enable, byte lanes and replicated store data for a legal request.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (mem_active) begin
            mem_en   = 1'b1;
            mem_addr = {bus.req_addr[31:2], 2'b00};
            if (bus.req_we) begin
                case (size_t'(bus.req_size))
                    SZ_B: begin
                        mem_we    = 4'b1000 >> bus.req_addr[1:0];
                        mem_wdata = {4{bus.req_wdata[7:0]}};
                    end
                    SZ_H: begin
                        mem_we    = bus.req_addr[1] ? 4'b0011 : 4'b1100;
                        mem_wdata = {2{bus.req_wdata[15:0]}};
                    end
                    default: begin
                        mem_we    = 4'b1111;
                        mem_wdata = bus.req_wdata;
                    end
                endcase
            end
        end
    end

    // Next-state logic: loads wait one cycle for RAM data, everything else responds directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (bus.req_we || req_err != ERR_OK) ? RESP : RD;
                end
            end
            RD:      state_nxt = RESP;
            RESP:    state_nxt = bus.resp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture at accept and load result registration in RD; held through RESP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_size     <= SZ_B;
            cap_offset   <= 2'b00;
            cap_zero_ext <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= ERR_OK;
        end else if (accept) begin
            cap_size     <= size_t'(bus.req_size);
            cap_offset   <= bus.req_addr[1:0];
            cap_zero_ext <= bus.req_unsigned;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= req_err;
        end else if (state == RD) begin
            resp_rdata_q <= load_data;
        end
    end

    lsu_load_align u_load_align (
        .rdata    (mem_rdata),
        .offset   (cap_offset),
        .size     (cap_size),
        .zero_ext (cap_zero_ext),
        .data     (load_data)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a byte-level reference memory.
module tb_mem_access_ctrl;

    localparam int RAM_SPACE = 4194304;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_pass = 0;
    int n_total = 0;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.RAM_SPACE(RAM_SPACE)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Stand-in for data_memory: word RAM, byte write enables, 1-cycle read latency.
    logic [31:0] ram [int unsigned];
    always @(posedge clk) begin : ram_model
        logic [31:0] w;
        if (mem_en) begin
            w = ram.exists(int'(mem_addr[31:2])) ? ram[int'(mem_addr[31:2])] : 32'h0;
            mem_rdata <= w;
            for (int l = 0; l < 4; l++) begin
                if (mem_we[l]) w[8*l +: 8] = mem_wdata[8*l +: 8];
            end
            ram[int'(mem_addr[31:2])] = w;
        end
    end

    // Reference memory, byte addressed.
    logic [7:0] model_mem [int unsigned];

    function automatic logic [7:0] model_rd(input int unsigned a);
        return model_mem.exists(a) ? model_mem[a] : 8'h00;
    endfunction

    function automatic logic [1:0] model_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 2'd1;
        if (size == 2'd1 && (addr % 2) != 0) return 2'd1;
        if (size == 2'd2 && (addr % 4) != 0) return 2'd1;
        if ((addr / 4) >= RAM_SPACE) return 2'd2;
        return 2'd0;
    endfunction

    // One full transaction; hold > 0 keeps resp_ready low that many cycles after resp_valid.
    task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        logic [1:0]  e_err;
        logic [31:0] e_rdata, e_maddr, e_mwdata;
        logic        e_en;
        logic [3:0]  e_we;
        logic [31:0] got_rdata;
        logic [1:0]  got_err;
        int n, off, lat, e_lat, stray;
        bit seen;

        n = 1 << size;
        off = int'(addr % 4);
        e_err = model_err(size, addr);
        e_en = 1'b0; e_we = 4'b0; e_maddr = 32'h0; e_mwdata = 32'h0; e_rdata = 32'h0;
        if (e_err == 2'd0) begin
            e_en = 1'b1;
            e_maddr = addr - (addr % 4);
            if (we) begin
                for (int i = 0; i < n; i++) e_we[3 - off - i] = 1'b1;
                e_mwdata = (n == 1) ? wdata[7:0] * 32'h01010101 :
                           (n == 2) ? wdata[15:0] * 32'h00010001 : wdata;
                for (int i = 0; i < n; i++) model_mem[addr + i] = 8'(wdata >> (8 * (n - 1 - i)));
            end else begin
                for (int i = 0; i < n; i++) e_rdata = (e_rdata << 8) | 32'(model_rd(addr + i));
                if (!uns && n < 4 && e_rdata[8*n-1]) e_rdata = e_rdata | ~((32'h1 << (8 * n)) - 1);
            end
        end
        e_lat = (!we && e_err == 2'd0) ? 2 : 1;

        @(negedge clk);
        bus.resp_ready   = (hold == 0);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        #1;
        n_total++;
        if (bus.req_ready !== 1'b1) $display("FAIL %s req_ready: got %b expected 1", name, bus.req_ready);
        else n_pass++;
        n_total++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_maddr, e_mwdata})
            $display("FAIL %s mem: got en=%b we=%b addr=%h wdata=%h expected en=%b we=%b addr=%h wdata=%h",
                     name, mem_en, mem_we, mem_addr, mem_wdata, e_en, e_we, e_maddr, e_mwdata);
        else n_pass++;

        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        seen = 0; lat = 0; stray = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (mem_en) stray++;
            if (bus.resp_valid) begin
                seen = 1;
                lat = c;
            end
        end
        n_total++;
        if (!seen || lat != e_lat || stray != 0)
            $display("FAIL %s latency: got %0d (seen=%0d, stray mem_en=%0d) expected %0d", name, lat, seen, stray, e_lat);
        else n_pass++;
        if (!seen) return;

        got_rdata = bus.resp_rdata;
        got_err   = bus.resp_err;
        n_total++;
        if (got_err !== e_err) $display("FAIL %s resp_err: got %0d expected %0d", name, got_err, e_err);
        else n_pass++;
        n_total++;
        if (got_rdata !== e_rdata) $display("FAIL %s resp_rdata: got %h expected %h", name, got_rdata, e_rdata);
        else n_pass++;

        if (hold == 0) begin
            @(posedge clk);
        end else begin
            for (int h = 1; h <= hold; h++) begin
                @(negedge clk);
                n_total++;
                if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                    bus.resp_rdata !== got_rdata || bus.resp_err !== got_err)
                    $display("FAIL %s hold cycle %0d: got valid=%b ready=%b rdata=%h err=%0d expected 1 0 %h %0d",
                             name, h, bus.resp_valid, bus.req_ready, bus.resp_rdata, bus.resp_err, got_rdata, got_err);
                else n_pass++;
            end
            bus.resp_ready = 1'b1;
            @(negedge clk);
            n_total++;
            if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
                $display("FAIL %s release: got ready=%b valid=%b expected 1 0", name, bus.req_ready, bus.resp_valid);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
        #1;
        n_total++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err} !== {1'b1, 1'b0, 32'h0, 2'd0})
            $display("FAIL reset outputs: got ready=%b valid=%b rdata=%h err=%0d expected 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        else n_pass++;
        n_total++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== 69'h0)
            $display("FAIL reset mem: got en=%b we=%b addr=%h wdata=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata);
        else n_pass++;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rstn = 1'b1;
    endtask

    task automatic test_store_load();
        do_req("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0);
        do_req("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        do_req("sb_13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 0);
        do_req("lb_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
        do_req("lbu_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
        do_req("sw_20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h80017FFF, 0);
        do_req("lh_20", 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 0);
        do_req("lh_22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0);
        do_req("lhu_20", 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 0);
        do_req("sh_26", 1'b1, 2'd1, 1'b0, 32'h26, 32'h0000BEEF, 0);
        do_req("lw_24", 1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 0);
        do_req("sw_top", 1'b1, 2'd2, 1'b0, 32'h00FFFFFC, 32'hA5A55A5A, 0);
        do_req("lw_top", 1'b0, 2'd2, 1'b0, 32'h00FFFFFC, 32'h0, 0);
    endtask

    task automatic test_errors();
        do_req("lw_misal", 1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0);
        do_req("sw_range", 1'b1, 2'd2, 1'b0, 32'h01000000, 32'hDEADBEEF, 0);
        do_req("sh_both", 1'b1, 2'd1, 1'b0, 32'h01000001, 32'h1234, 0);
        do_req("size3", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
        do_req("lw_after_err", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        do_req("lw_hold", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
        do_req("sb_hold", 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000005C, 3);
    endtask

    task automatic test_reset_mid_read();
        int bad;
        do_req("sw_40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEBABE, 0);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h40;
        @(posedge clk);
        #1;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_total++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'b0)
            $display("FAIL rst_rd during: got valid=%b ready=%b mem_en=%b mem_we=%b expected 0 1 0 0",
                     bus.resp_valid, bus.req_ready, mem_en, mem_we);
        else n_pass++;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rstn = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL rst_rd after: got %0d cycles with stray response or not ready expected 0", bad);
        else n_pass++;
        do_req("lw_40_post_rst", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [1:0]  size;
        int r;
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 9));
            size = 2'($urandom_range(0, 3));
            if (r == 0)      addr = 32'h01000000 + $urandom_range(0, 15);
            else if (r == 1) addr = 32'h00FFFFF0 + $urandom_range(0, 15);
            else             addr = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~((32'h1 << size) - 1);
            do_req("rand", 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom,
                   ($urandom_range(0, 7) == 0) ? 2 : 0);
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.resp_ready   = 1'b1;
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
